// File: rtl/otbn_bignum_wb_queue_if.sv
// rtl/otbn_bignum_wb_queue_if.sv - producer, RF write, RF read and status signals of the WDR write-back queue
interface otbn_bignum_wb_queue_if #(
  parameter int WLEN  = 256,
  parameter int WdrAw = 5,
  parameter int NWdr  = 32
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WdrAw-1:0] in_addr_i;
  logic [7:0]       in_en_i;
  logic [WLEN-1:0]  in_data_i;
  logic             drain_en_i;
  logic             flush_i;
  logic [WdrAw-1:0] wr_addr_a_o;
  logic [WdrAw-1:0] wr_addr_b_o;
  logic [7:0]       wr_en_a_o;
  logic [7:0]       wr_en_b_o;
  logic [WLEN-1:0]  wr_data_a_o;
  logic [WLEN-1:0]  wr_data_b_o;
  logic             wr_commit_o;
  logic [NWdr-1:0]  rf_we_a_o;
  logic [NWdr-1:0]  rf_we_b_o;
  logic             rd_en_a_i;
  logic             rd_en_b_i;
  logic [WdrAw-1:0] rd_addr_a_i;
  logic [WdrAw-1:0] rd_addr_b_i;
  logic             hazard_o;
  logic             empty_o;
  logic             err_o;

  modport slave (
    input  in_valid_i, in_addr_i, in_en_i, in_data_i, drain_en_i, flush_i,
           rd_en_a_i, rd_en_b_i, rd_addr_a_i, rd_addr_b_i,
    output in_ready_o, wr_addr_a_o, wr_addr_b_o, wr_en_a_o, wr_en_b_o,
           wr_data_a_o, wr_data_b_o, wr_commit_o, rf_we_a_o, rf_we_b_o,
           hazard_o, empty_o, err_o
  );

  modport master (
    output in_valid_i, in_addr_i, in_en_i, in_data_i, drain_en_i, flush_i,
           rd_en_a_i, rd_en_b_i, rd_addr_a_i, rd_addr_b_i,
    input  in_ready_o, wr_addr_a_o, wr_addr_b_o, wr_en_a_o, wr_en_b_o,
           wr_data_a_o, wr_data_b_o, wr_commit_o, rf_we_a_o, rf_we_b_o,
           hazard_o, empty_o, err_o
  );
endinterface

// File: rtl/otbn_bignum_wb_queue.sv
// rtl/otbn_bignum_wb_queue.sv - in-order WDR write-back queue draining up to two writes per cycle
// Optional RAW hazard detection against pending entries: define OTBN_WBQ_HAZARD_EN.
module otbn_bignum_wb_queue #(
  parameter int Depth = 4,
  parameter int WLEN  = 256,
  parameter int WdrAw = 5,
  parameter int NWdr  = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  otbn_bignum_wb_queue_if.slave  bus
);
  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;

  logic [PtrW-1:0]  rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             err_q, err_d;
  logic [WdrAw-1:0] addr_q [Depth];
  logic [WdrAw-1:0] addr_d [Depth];
  logic [7:0]       en_q   [Depth];
  logic [7:0]       en_d   [Depth];
  logic [WLEN-1:0]  data_q [Depth];
  logic [WLEN-1:0]  data_d [Depth];

  logic            in_ready, push, store, drain_ok, act_a, act_b, overrun, cnt_bad;
  logic [1:0]      pop;
  logic [PtrW-1:0] head_idx, next_idx, ptr_diff;

  assign in_ready = (count_q < CntW'(Depth));
  assign head_idx = rptr_q;
  assign next_idx = rptr_q + PtrW'(1);
  assign ptr_diff = wptr_q - rptr_q;

  always_comb begin
    drain_ok = bus.drain_en_i && !bus.flush_i && (count_q != '0);
    act_a    = drain_ok;
    // Same destination back to back must commit in separate cycles to keep write order.
    act_b    = drain_ok && (count_q >= CntW'(2)) && (addr_q[next_idx] != addr_q[head_idx]);
    pop      = {1'b0, act_a} + {1'b0, act_b};
    push     = bus.in_valid_i && in_ready && !bus.flush_i;
    store    = push && (bus.in_en_i != 8'd0);
    overrun  = bus.in_valid_i && !in_ready && !bus.flush_i;
    cnt_bad  = (count_q != {1'b0, ptr_diff}) &&
               !((count_q == CntW'(Depth)) && (ptr_diff == '0));
  end

  always_comb begin
    addr_d  = addr_q;
    en_d    = en_q;
    data_d  = data_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    err_d   = err_q | overrun | cnt_bad;
    if (bus.flush_i) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      if (store) begin
        addr_d[wptr_q] = bus.in_addr_i;
        en_d[wptr_q]   = bus.in_en_i;
        data_d[wptr_q] = bus.in_data_i;
        wptr_d         = wptr_q + PtrW'(1);
      end
      rptr_d  = rptr_q + PtrW'(pop);
      count_d = count_q + CntW'(store) - CntW'(pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < Depth; i++) begin
        addr_q[i] <= '0;
        en_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      en_q    <= en_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    bus.wr_addr_a_o = '0;
    bus.wr_en_a_o   = '0;
    bus.wr_data_a_o = '0;
    bus.rf_we_a_o   = '0;
    bus.wr_addr_b_o = '0;
    bus.wr_en_b_o   = '0;
    bus.wr_data_b_o = '0;
    bus.rf_we_b_o   = '0;
    if (act_a) begin
      bus.wr_addr_a_o = addr_q[head_idx];
      bus.wr_en_a_o   = en_q[head_idx];
      bus.wr_data_a_o = data_q[head_idx];
      if (en_q[head_idx] != 8'd0) begin
        bus.rf_we_a_o = {{(NWdr-1){1'b0}}, 1'b1} << addr_q[head_idx];
      end
    end
    if (act_b) begin
      bus.wr_addr_b_o = addr_q[next_idx];
      bus.wr_en_b_o   = en_q[next_idx];
      bus.wr_data_b_o = data_q[next_idx];
      if (en_q[next_idx] != 8'd0) begin
        bus.rf_we_b_o = {{(NWdr-1){1'b0}}, 1'b1} << addr_q[next_idx];
      end
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.wr_commit_o = act_a;
  assign bus.empty_o     = (count_q == '0);
  assign bus.err_o       = err_q;

`ifdef OTBN_WBQ_HAZARD_EN
  logic            hit_a, hit_b;
  logic [PtrW-1:0] scan_idx;

  // Entries being drained this cycle still count as pending; a same-cycle push does not.
  always_comb begin
    hit_a    = 1'b0;
    hit_b    = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < Depth; k++) begin
      scan_idx = rptr_q + PtrW'(k);
      if (CntW'(k) < count_q) begin
        if (addr_q[scan_idx] == bus.rd_addr_a_i) hit_a = 1'b1;
        if (addr_q[scan_idx] == bus.rd_addr_b_i) hit_b = 1'b1;
      end
    end
  end

  assign bus.hazard_o = (bus.rd_en_a_i && hit_a) || (bus.rd_en_b_i && hit_b);
`else
  logic unused_rd;
  assign unused_rd    = ^{bus.rd_en_a_i, bus.rd_en_b_i, bus.rd_addr_a_i, bus.rd_addr_b_i};
  assign bus.hazard_o = 1'b0;
`endif
endmodule
